// File: rtl/uart_loader.sv
// uart_loader: serial program loader. Receives a framed image on a UART RX
// line and writes it word-by-word into CPU RAM. The CPU is held in reset
// while a load runs and is released only when the image checksum matches.
//
// Frame: SYNC_BYTE, LEN_LO, LEN_HI, 4*N data bytes, CSUM (sum of data bytes).
//
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous reset, active-low
//   i_rx     UART receive line (idle high, asynchronous)
//   o_we     RAM write strobe, one cycle per word
//   o_addr   RAM word address (holds between strobes)
//   o_wdata  RAM write data (little-endian assembled word)
//   o_hold   CPU reset request
//   o_busy   frame in progress
//   o_done   one-cycle pulse on a verified load
//   o_err    sticky error flag, cleared by the next SYNC_BYTE
module uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned ADDR_W       = 10,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_wdata,
  output logic              o_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF      = CLKS_PER_BIT / 2;
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;
  localparam int unsigned WIDX_W    = ADDR_W + 1;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  // RX synchronizer; rx_prev_q gives falling-edge detection so a low line
  // after a framing error does not retrigger the receiver.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       wacc_q, wacc_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [15:0] n_c;

  // UART receiver: start-bit check at half bit, data LSB first, then stop.
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    sh_d         = sh_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_sync_q, sh_q[7:1]};
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
          else               bit_d      = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = sh_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Loader FSM: frame parsing, word assembly and RAM write strobes.
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    widx_d   = widx_q;
    bcnt_d   = bcnt_q;
    wacc_d   = wacc_q;
    csum_d   = csum_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    n_c      = {rx_byte_q, len_lo_q};

    if (frame_err_q && (state_q != S_IDLE) && (state_q != S_ERR)) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (byte_valid_q) begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (rx_byte_q == SYNC_BYTE) begin
            state_d = S_LEN_LO;
            busy_d  = 1'b1;
            hold_d  = 1'b1;
            err_d   = 1'b0;
            widx_d  = '0;
            bcnt_d  = '0;
            csum_d  = '0;
          end
        end
        S_LEN_LO: begin
          len_lo_d = rx_byte_q;
          state_d  = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d = n_c;
          if (32'(n_c) > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else if (n_c == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          csum_d = csum_q + rx_byte_q;
          bcnt_d = bcnt_q + 2'd1;
          wacc_d = {rx_byte_q, wacc_q[23:8]};
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_W-1:0];
            wdata_d = {rx_byte_q, wacc_q};
            widx_d  = widx_q + WIDX_W'(1);
            if (16'(widx_q) + 16'd1 == len_q) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_byte_q == csum_q) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      widx_q       <= '0;
      bcnt_q       <= '0;
      wacc_q       <= '0;
      csum_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      hold_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_meta_q    <= i_rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      widx_q       <= widx_d;
      bcnt_q       <= bcnt_d;
      wacc_q       <= wacc_d;
      csum_q       <= csum_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      hold_q       <= hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign o_we    = we_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_hold  = hold_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: table of whole frames with expected end state and
// writes, then hand sequences for glitch, framing error, max length and
// asynchronous reset mid-frame.
module tb_uart_loader;

  localparam int unsigned CPB = 8;
  localparam int unsigned AW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          o_we;
  logic [AW-1:0] o_addr;
  logic [31:0]   o_wdata;
  logic          o_hold, o_busy, o_done, o_err;

  uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_rx   (rx),
    .o_we   (o_we),
    .o_addr (o_addr),
    .o_wdata(o_wdata),
    .o_hold (o_hold),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            done_cnt = 0;

  // Record every write strobe and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_we) begin
      wa_q.push_back(o_addr);
      wd_q.push_back(o_wdata);
    end
    if (o_done) done_cnt++;
  end

  typedef struct {
    string            name;
    int               nb;
    logic [0:11][7:0] b;
    int               nw;
    logic [0:1][31:0] wd;
    logic             done;
    logic             err;
    logic             hold;
    logic             busy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
  endtask

  task automatic check_writes(input string name, input int n, input logic [0:1][31:0] wd);
    check($sformatf("%s/nwrites", name), 32'(wa_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wa_q.size()) begin
        check($sformatf("%s/addr%0d", name, i), 32'(wa_q[i]), 32'(i));
        check($sformatf("%s/data%0d", name, i), wd_q[i], wd[i]);
      end
    end
  endtask

  task automatic check_state(input string name, input logic done, input logic err,
                             input logic hold, input logic busy);
    check($sformatf("%s/done", name), 32'(done_cnt), 32'(done));
    check($sformatf("%s/err", name), 32'(o_err), 32'(err));
    check($sformatf("%s/hold", name), 32'(o_hold), 32'(hold));
    check($sformatf("%s/busy", name), 32'(o_busy), 32'(busy));
  endtask

  logic [0:1][31:0] prog_wd;
  logic [0:1][31:0] no_wd;
  logic [7:0]       cs;
  logic [7:0]       db;

  initial begin
    // Data bytes 13 05 A0 00 93 85 05 00 sum to 0xD5 modulo 256.
    prog_wd = {32'h00A00513, 32'h00058593};
    no_wd   = '0;
    vecs[0] = '{"valid", 12, {8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                8'h93, 8'h85, 8'h05, 8'h00, 8'hD5}, 2, prog_wd, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"badcsum", 12, {8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                8'h93, 8'h85, 8'h05, 8'h00, 8'h5D}, 2, prog_wd, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{"reload", 12, {8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                8'h93, 8'h85, 8'h05, 8'h00, 8'hD5}, 2, prog_wd, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"garbage", 3, {8'h00, 8'hFF, 8'h5A, 72'h0}, 0, no_wd,
                1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"len0", 4, {8'hA5, 8'h00, 8'h00, 8'h00, 64'h0}, 0, no_wd,
                1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"len17", 3, {8'hA5, 8'h11, 8'h00, 72'h0}, 0, no_wd,
                1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset/flags", 32'({o_we, o_hold, o_busy, o_done, o_err}), 32'd0);
    check("reset/addr", 32'(o_addr), 32'd0);
    check("reset/wdata", o_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      clear_mon();
      for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].b[i], 1'b1);
      repeat (4) @(negedge clk);
      check_writes(vecs[v].name, vecs[v].nw, vecs[v].wd);
      check_state(vecs[v].name, vecs[v].done, vecs[v].err, vecs[v].hold, vecs[v].busy);
    end

    // From ERR: the sync byte alone clears o_err and re-asserts busy/hold.
    clear_mon();
    send_byte(8'hA5, 1'b1);
    check_state("errclr_sync", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i < 12; i++) send_byte(vecs[0].b[i], 1'b1);
    repeat (4) @(negedge clk);
    check_writes("errclr_end", 2, prog_wd);
    check_state("errclr_end", 1'b1, 1'b0, 1'b0, 1'b0);

    // Two-cycle low pulse in IDLE is rejected as a glitch.
    clear_mon();
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check_writes("glitch", 0, no_wd);
    check_state("glitch", 1'b0, 1'b0, 1'b0, 1'b0);

    // Framing error on the second data byte.
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b0);
    repeat (4) @(negedge clk);
    check_writes("framerr", 0, no_wd);
    check_state("framerr", 1'b0, 1'b1, 1'b1, 1'b0);

    // Maximum image: 16 words, data byte k = k.
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    cs = 8'h00;
    for (int k = 0; k < 64; k++) begin
      db = 8'(k);
      cs = cs + db;
      send_byte(db, 1'b1);
    end
    send_byte(cs, 1'b1);
    repeat (4) @(negedge clk);
    check("len16/nwrites", 32'(wa_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < wa_q.size()) begin
        check($sformatf("len16/addr%0d", i), 32'(wa_q[i]), 32'(i));
        check($sformatf("len16/data%0d", i), wd_q[i],
              {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
      end
    end
    check_state("len16", 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset after word 0 of a two-word frame.
    clear_mon();
    for (int i = 0; i < 7; i++) send_byte(vecs[0].b[i], 1'b1);
    check("rstmid/word0", 32'(wa_q.size()), 32'd1);
    check("rstmid/busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid/flags", 32'({o_we, o_hold, o_busy, o_done, o_err}), 32'd0);
    check("rstmid/addr", 32'(o_addr), 32'd0);
    check("rstmid/wdata", o_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 7; i < 12; i++) send_byte(vecs[0].b[i], 1'b1);
    repeat (4) @(negedge clk);
    check("rstmid/nowrite", 32'(wa_q.size()), 32'd1);
    check_state("rstmid/after", 1'b0, 1'b0, 1'b0, 1'b0);

    clear_mon();
    for (int i = 0; i < 12; i++) send_byte(vecs[0].b[i], 1'b1);
    repeat (4) @(negedge clk);
    check_writes("rstmid/reload", 2, prog_wd);
    check_state("rstmid/reload", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
